demux_chan_deserializer: RTL and testbench
==========================================

// Module: demux_chan_deserializer
// PURPOSE
//  Downstream stage of the 1x2 demux. Consumes the demux's 2-bit one-hot channel strobe plus the serial data bit.
//  Assembles WIDTH-bit words per channel (ch0 = 2'b01, ch1 = 2'b10).
//  Presents each channel's words on an independent valid/ready output port.
//  Back-pressures the serial input only when the addressed channel cannot absorb another bit.
// PARAMETERS
//  WIDTH      8   bits per assembled word (legal range 2..32)
//  MSB_FIRST  1   1: first accepted bit lands in word[WIDTH-1]; 0: first bit lands in word[0]
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      serial bit present on din this cycle
//  din        in   1      serial data bit
//  chan_oh    in   2      one-hot channel strobe from demux (01 = ch0, 10 = ch1)
//  in_ready   out  1      combinational; bit accepted on edge when in_valid & in_ready
//  out0_data  out  WIDTH  ch0 assembled word
//  out0_valid out  1      ch0 word available
//  out0_ready in   1      ch0 consumer accepts word
//  out1_data  out  WIDTH  ch1 assembled word
//  out1_valid out  1      ch1 word available
//  out1_ready in   1      ch1 consumer accepts word
//  err_sel    out  1      one-cycle pulse: previous cycle had in_valid with chan_oh = 00 or 11
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - all accumulators, bit counters and holding regs cleared to 0
//   - FSMs to FILL; outN_valid = 0, err_sel = 0
//   - any partial word is discarded
//  Per channel: shift accumulator, counter 0..WIDTH-1, holding reg (outN_data), FSM {FILL, WAIT}.
//  Accept for ch N: in_valid & in_ready & chan_oh == one-hot N. The bit shifts in and the counter increments.
//  FILL, bit accepted, counter == WIDTH-1:
//   - if holding empty or draining this cycle (outN_valid & outN_ready): word loads holding, outN_valid = 1 next cycle, counter -> 0, stay FILL
//   - otherwise: full word kept in accumulator, counter -> 0, go WAIT
//  WAIT: on edge where outN_valid & outN_ready, accumulator -> holding, outN_valid stays 1, go FILL.
//  in_ready = 1 unless chan_oh selects a channel in WAIT. Invalid chan_oh -> in_ready = 1.
//  Invalid chan_oh (00/11) with in_valid: bit dropped, no state change, err_sel = 1 next cycle.
//  outN_valid clears on handshake edge unless a new word loads on the same edge.
//  outN_data is stable while outN_valid & ~outN_ready.
//  Channels are fully independent: a ch1 stall never blocks ch0 bits.
//  Latency: WIDTH-th bit accepted at edge k -> outN_valid high after edge k (1 cycle) when holding is free.
//  Simultaneous events: final bit + drain on the same edge yields back-to-back valid words with no bubble.
//  Reset mid-word or mid-WAIT: word is lost and no partial output appears.
// TESTING
//  1. WIDTH=8, MSB_FIRST=1, ch0, bits 1,0,1,0,0,1,0,1, out0_ready=1
//     -> out0_data = 8'hA5, out0_valid for 1 cycle after edge 8.
//  2. Interleave ch0/ch1 bits, with ch0 word 8'h3C and ch1 word 8'hF0
//     -> each port emits its own word and no cross-talk.
//  3. out1_ready=0; send two ch1 words 8'h11, 8'h22
//     -> FSM in WAIT, in_ready=0 when chan_oh=10, in_ready=1 when chan_oh=01.
//     Release ready -> 8'h11 then 8'h22 on consecutive accepts.
//  4. in_valid with chan_oh=00, then 11 -> err_sel pulses on both following cycles; counters unchanged.
//  5. rst asserted after 5 bits of ch0 -> outputs 0; the next 8 bits yield a clean word containing only the new bits.
//  6. MSB_FIRST=0, bits 1,0,1,0,0,0,0,0 -> out0_data = 8'h05.

Source files
------------

// File: rtl/demux_chan_deserializer.sv
// Two-channel serial-to-parallel stage behind a 1x2 demux: each one-hot channel
// assembles WIDTH-bit words into its own holding register with valid/ready output.
module demux_chan_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             din,
  input  logic [1:0]       chan_oh,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             err_sel
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [1:0]       w_out_ready;
  logic [1:0]       w_valid;
  logic [1:0]       w_wait;
  logic [WIDTH-1:0] w_hold [2];
  logic             r_err;

  assign w_out_ready = {out1_ready, out0_ready};

  // Only a channel parked in WAIT stalls the input, and only while it is addressed.
  always_comb begin
    in_ready = 1'b1;
    if (chan_oh == 2'b01) in_ready = ~w_wait[0];
    else if (chan_oh == 2'b10) in_ready = ~w_wait[1];
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      localparam logic [1:0] OH = 2'(1 << gi);

      state_t           r_state, w_state_next;
      logic [WIDTH-1:0] r_acc, w_acc_next;
      logic [CW-1:0]    r_cnt, w_cnt_next;
      logic [WIDTH-1:0] r_hold, w_hold_next;
      logic             r_valid, w_valid_next;
      logic             w_accept, w_drain;
      logic [WIDTH-1:0] w_shift;

      assign w_accept = in_valid & in_ready & (chan_oh == OH);
      assign w_drain  = r_valid & w_out_ready[gi];
      assign w_shift  = MSB_FIRST ? {r_acc[WIDTH-2:0], din} : {din, r_acc[WIDTH-1:1]};

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= S_FILL;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_hold  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_state <= w_state_next;
          r_acc   <= w_acc_next;
          r_cnt   <= w_cnt_next;
          r_hold  <= w_hold_next;
          r_valid <= w_valid_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_hold_next  = r_hold;
        w_valid_next = r_valid & ~w_drain;
        case (r_state)
          S_FILL: begin
            if (w_accept) begin
              w_acc_next = w_shift;
              if (r_cnt == CW'(WIDTH - 1)) begin
                w_cnt_next = '0;
                if (!r_valid || w_drain) begin
                  w_hold_next  = w_shift;
                  w_valid_next = 1'b1;
                end else begin
                  w_state_next = S_WAIT;
                end
              end else begin
                w_cnt_next = r_cnt + CW'(1);
              end
            end
          end
          S_WAIT: begin
            // Completed word parked in the accumulator moves up as the holding reg drains.
            if (w_drain) begin
              w_hold_next  = r_acc;
              w_valid_next = 1'b1;
              w_state_next = S_FILL;
            end
          end
          default: w_state_next = S_FILL;
        endcase
      end

      assign w_valid[gi] = r_valid;
      assign w_wait[gi]  = (r_state == S_WAIT);
      assign w_hold[gi]  = r_hold;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= in_valid & ((chan_oh == 2'b00) | (chan_oh == 2'b11));
  end

  assign out0_data  = w_hold[0];
  assign out0_valid = w_valid[0];
  assign out1_data  = w_hold[1];
  assign out1_valid = w_valid[1];
  assign err_sel    = r_err;

endmodule

// File: tb/tb_demux_chan_deserializer.sv
// Bench for demux_chan_deserializer: an MSB-first and an LSB-first instance share stimulus
// and are compared every cycle against a queue-based per-channel word model.
module tb_demux_chan_deserializer;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst, in_valid, din, out0_ready, out1_ready;
  logic [1:0] chan_oh;
  logic [1:0] in_ready_s, o0_valid_s, o1_valid_s, err_s;
  logic [WIDTH-1:0] o0_data_s [2];
  logic [WIDTH-1:0] o1_data_s [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per dut/channel, up to two completed words awaiting output plus a partial word.
  logic [WIDTH-1:0] mq [2][2][2];
  int               mqn [2][2];
  logic [WIDTH-1:0] pword [2][2];
  int               pcnt [2][2];
  bit               err_exp;

  always #5 clk = ~clk;

  demux_chan_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .chan_oh(chan_oh),
    .in_ready(in_ready_s[0]),
    .out0_data(o0_data_s[0]), .out0_valid(o0_valid_s[0]), .out0_ready(out0_ready),
    .out1_data(o1_data_s[0]), .out1_valid(o1_valid_s[0]), .out1_ready(out1_ready),
    .err_sel(err_s[0])
  );

  demux_chan_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .chan_oh(chan_oh),
    .in_ready(in_ready_s[1]),
    .out0_data(o0_data_s[1]), .out0_valid(o0_valid_s[1]), .out0_ready(out0_ready),
    .out1_data(o1_data_s[1]), .out1_valid(o1_valid_s[1]), .out1_ready(out1_ready),
    .err_sel(err_s[1])
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(int d);
    if (chan_oh == 2'b01) return mqn[d][0] < 2;
    if (chan_oh == 2'b10) return mqn[d][1] < 2;
    return 1'b1;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          mqn[d][c] = 0; pcnt[d][c] = 0; pword[d][c] = '0;
        end else begin
          bit acc, rdy_o;
          int pos;
          acc   = in_valid && (chan_oh == ((c == 0) ? 2'b01 : 2'b10)) && (mqn[d][c] < 2);
          rdy_o = (c == 0) ? out0_ready : out1_ready;
          if (mqn[d][c] > 0 && rdy_o) begin
            mq[d][c][0] = mq[d][c][1];
            mqn[d][c]--;
          end
          if (acc) begin
            pos = (d == 0) ? (WIDTH - 1 - pcnt[d][c]) : pcnt[d][c];
            pword[d][c][pos] = din;
            pcnt[d][c]++;
            if (pcnt[d][c] == WIDTH) begin
              mq[d][c][mqn[d][c]] = pword[d][c];
              mqn[d][c]++;
              pcnt[d][c] = 0;
              pword[d][c] = '0;
            end
          end
        end
      end
    end
    err_exp = !rst && in_valid && (chan_oh == 2'b00 || chan_oh == 2'b11);
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("d%0d_in_ready", d), 32'(in_ready_s[d]), 32'(model_ready(d)));
      chk_eq($sformatf("d%0d_out0_valid", d), 32'(o0_valid_s[d]), 32'(mqn[d][0] > 0));
      chk_eq($sformatf("d%0d_out1_valid", d), 32'(o1_valid_s[d]), 32'(mqn[d][1] > 0));
      if (mqn[d][0] > 0) chk_eq($sformatf("d%0d_out0_data", d), 32'(o0_data_s[d]), 32'(mq[d][0][0]));
      if (mqn[d][1] > 0) chk_eq($sformatf("d%0d_out1_data", d), 32'(o1_data_s[d]), 32'(mq[d][1][0]));
      chk_eq($sformatf("d%0d_err_sel", d), 32'(err_s[d]), 32'(err_exp));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_bit(input logic [1:0] ch, input logic b);
    in_valid = 1'b1; chan_oh = ch; din = b;
    step();
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(ch, w[i]);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] seq;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        mqn[d][c] = 0; pcnt[d][c] = 0; pword[d][c] = '0;
      end
    err_exp = 1'b0;
    rst = 1'b1; in_valid = 1'b0; din = 1'b0; chan_oh = 2'b01;
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(posedge clk); model_edge(); #1;
    step();
    rst = 1'b0;
    chk_eq("rst_out0_data", 32'(o0_data_s[0]), 32'h0);
    chk_eq("rst_out1_data", 32'(o1_data_s[1]), 32'h0);
    chk_eq("rst_out0_valid", 32'(o0_valid_s[0]), 32'h0);
    chk_eq("rst_err_sel", 32'(err_s[0]), 32'h0);

    // Word 1,0,1,0,0,1,0,1 on ch0
    seq = 8'b10100101;
    for (int i = 0; i < 8; i++) send_bit(2'b01, seq[7-i]);
    in_valid = 1'b0;
    chk_eq("a5_msb_data", 32'(o0_data_s[0]), 32'hA5);
    chk_eq("a5_lsb_data", 32'(o0_data_s[1]), 32'hA5);
    chk_eq("a5_valid", 32'(o0_valid_s[0]), 32'h1);
    step();
    chk_eq("a5_valid_one_cycle", 32'(o0_valid_s[0]), 32'h0);

    // Bit order: 1,0,1,0,0,0,0,0
    seq = 8'b10100000;
    for (int i = 0; i < 8; i++) send_bit(2'b01, seq[7-i]);
    in_valid = 1'b0;
    chk_eq("order_lsb_data", 32'(o0_data_s[1]), 32'h05);
    chk_eq("order_msb_data", 32'(o0_data_s[0]), 32'hA0);
    step();

    // Interleaved channels
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w0, w1;
      w0 = 8'h3C; w1 = 8'hF0;
      send_bit(2'b01, w0[i]);
      if (i == 0) chk_eq("ilv_out0_data", 32'(o0_data_s[0]), 32'h3C);
      send_bit(2'b10, w1[i]);
    end
    in_valid = 1'b0;
    chk_eq("ilv_out1_data", 32'(o1_data_s[0]), 32'hF0);
    chk_eq("ilv_out1_lsb", 32'(o1_data_s[1]), 32'h0F);
    step();

    // Stalled ch1 backs up into WAIT
    out1_ready = 1'b0;
    send_word(2'b10, 8'h11);
    send_word(2'b10, 8'h22);
    in_valid = 1'b1; chan_oh = 2'b10; #1;
    chk_eq("wait_ready_ch1", 32'(in_ready_s[0]), 32'h0);
    chan_oh = 2'b01; #1;
    chk_eq("wait_ready_ch0", 32'(in_ready_s[0]), 32'h1);
    in_valid = 1'b0;
    step();
    out1_ready = 1'b1; #1;
    chk_eq("rel_first", 32'(o1_data_s[0]), 32'h11);
    step();
    chk_eq("rel_second", 32'(o1_data_s[0]), 32'h22);
    chk_eq("rel_second_valid", 32'(o1_valid_s[0]), 32'h1);
    step();
    chk_eq("rel_empty", 32'(o1_valid_s[0]), 32'h0);

    // Invalid channel codes
    in_valid = 1'b1; chan_oh = 2'b00; step();
    chk_eq("err_00", 32'(err_s[0]), 32'h1);
    chan_oh = 2'b11; step();
    chk_eq("err_11", 32'(err_s[0]), 32'h1);
    in_valid = 1'b0; step();
    chk_eq("err_clear", 32'(err_s[0]), 32'h0);

    // Reset mid-word
    for (int i = 0; i < 5; i++) send_bit(2'b01, 1'b1);
    in_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    chk_eq("midrst_valid", 32'(o0_valid_s[0]), 32'h0);
    chk_eq("midrst_data", 32'(o0_data_s[0]), 32'h0);
    send_word(2'b01, 8'h5A);
    chk_eq("midrst_word", 32'(o0_data_s[0]), 32'h5A);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      in_valid   = ($urandom_range(0, 3) != 0);
      din        = 1'($urandom);
      chan_oh    = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 9) ? 2'b01 : 2'b10;
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 255) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
